branch_resolver: RTL

- Consumes the execute-stage compare flags (isLessThan, isNotEqual) produced by the subtractor and turns them into a control-flow decision for the pipeline.
- Decides taken/not-taken for bne/blt, computes the target for branches, j/jal and jr, and detects mispredictions against the fetch-stage guess.
- On a misprediction it drives a held PC redirect to fetch (valid/ack handshake), then flushes the younger stages for a programmable window.
- Sits between the execute stage and the fetch/decode pipeline registers.

---
 rtl/branch_resolver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: taken/target decode, mispredict detection,
// held PC redirect to fetch and a post-redirect flush window.
// Optional stats counters are enabled by defining BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_bne,
  input  logic        ex_is_blt,
  input  logic        ex_is_j,
  input  logic        ex_is_jr,
  input  logic [31:0] ex_pc_plus1,
  input  logic [31:0] ex_imm,
  input  logic [26:0] ex_jtarget,
  input  logic [31:0] ex_reg_val,
  input  logic        isLessThan,
  input  logic        isNotEqual,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic        flush
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  logic        redirect_valid_n;
  logic [31:0] redirect_pc_n;
  logic        flush_n;
  logic [3:0]  count, count_n;

  logic        is_cf;
  logic        taken;
  logic [31:0] target;
  logic [31:0] fix_pc;
  logic        mispredict;
  logic        accept;

  // Control-flow decode; jr > j > blt > bne when more than one flag is set.
  always_comb begin
    is_cf = ex_is_bne | ex_is_blt | ex_is_j | ex_is_jr;
    taken = (ex_is_bne & isNotEqual) | (ex_is_blt & isLessThan) | ex_is_j | ex_is_jr;
    if (ex_is_jr) begin
      target = ex_reg_val;
    end else if (ex_is_j) begin
      target = {ex_pc_plus1[31:27], ex_jtarget};
    end else begin
      target = ex_pc_plus1 + ex_imm;
    end
    fix_pc = taken ? target : ex_pc_plus1;
    mispredict = is_cf & ((taken & ~pred_taken) |
                          (~taken & pred_taken) |
                          (taken & pred_taken & (pred_target != target)));
  end

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready;

  always_comb begin
    state_n          = state;
    redirect_valid_n = redirect_valid;
    redirect_pc_n    = redirect_pc;
    flush_n          = flush;
    count_n          = count;
    unique case (state)
      IDLE: begin
        if (accept && mispredict) begin
          state_n          = REDIRECT;
          redirect_valid_n = 1'b1;
          redirect_pc_n    = fix_pc;
          flush_n          = 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_ack) begin
          redirect_valid_n = 1'b0;
          if (FLUSH_CYCLES == 0) begin
            state_n = IDLE;
            flush_n = 1'b0;
          end else begin
            state_n = FLUSH;
            count_n = FLUSH_LOAD;
          end
        end
      end
      FLUSH: begin
        if (count == 4'd0) begin
          state_n = IDLE;
          flush_n = 1'b0;
        end else begin
          count_n = count - 4'd1;
        end
      end
      default: begin
        state_n          = IDLE;
        redirect_valid_n = 1'b0;
        flush_n          = 1'b0;
        count_n          = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      count          <= '0;
    end else begin
      state          <= state_n;
      redirect_valid <= redirect_valid_n;
      redirect_pc    <= redirect_pc_n;
      flush          <= flush_n;
      count          <= count_n;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (accept && is_cf) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (accept && mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule
